// File: rtl/cnn_layer_accel_dispatch_pkg.sv
// Shared types and default widths for the cnn_layer_accel host-side job dispatcher.
package cnn_layer_accel_dispatch_pkg;

  localparam int unsigned DEF_PARAM_WIDTH     = 128;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1000000;
  localparam int unsigned DEF_FETCH_CNT_WIDTH = 16;
  localparam int unsigned DEF_JOB_CNT_WIDTH   = 32;
  localparam int unsigned WDOG_CNT_WIDTH      = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    FACK,
    FETCH,
    CACK
  } dispatch_state_t;

  typedef logic [DEF_PARAM_WIDTH-1:0] job_desc_t;

endpackage

// File: rtl/cnn_layer_accel_watchdog.sv
// Cycle watchdog: cleared by load, counts while enabled, flags expiry at limit cycles.
// A limit of zero never expires.
module cnn_layer_accel_watchdog #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (en && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q is 0 in the first enabled cycle, so this fires in the limit-th cycle
  assign expired = en && (limit != '0) && (cnt_q >= (limit - 1'b1));

endmodule

// File: rtl/cnn_layer_accel_job_dispatcher.sv
// Host-side initiator for the cnn_layer_accel_quad job protocol: issues jobs,
// services fetch requests through an external DMA and acknowledges completion.
module cnn_layer_accel_job_dispatcher
  import cnn_layer_accel_dispatch_pkg::*;
#(
  parameter int unsigned C_PARAM_WIDTH     = DEF_PARAM_WIDTH,
  parameter int unsigned C_TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned C_FETCH_CNT_WIDTH = DEF_FETCH_CNT_WIDTH,
  parameter int unsigned C_JOB_CNT_WIDTH   = DEF_JOB_CNT_WIDTH
) (
  input  logic                         clk_if,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [C_PARAM_WIDTH-1:0]     cmd_params,
  output logic                         job_start,
  input  logic                         job_accept,
  output logic [C_PARAM_WIDTH-1:0]     job_parameters,
  input  logic                         job_fetch_request,
  output logic                         job_fetch_ack,
  output logic                         job_fetch_complete,
  input  logic                         job_complete,
  output logic                         job_complete_ack,
  output logic                         dma_start,
  input  logic                         dma_done,
  output logic                         busy,
  output logic [C_FETCH_CNT_WIDTH-1:0] fetch_count,
  output logic [C_JOB_CNT_WIDTH-1:0]   jobs_done,
  output logic                         err_timeout,
  output logic                         err_proto,
  input  logic                         err_clr
);

  localparam logic [WDOG_CNT_WIDTH-1:0] WDOG_LIMIT = WDOG_CNT_WIDTH'(C_TIMEOUT_CYCLES);

  dispatch_state_t state_q, state_d;

  logic                         cmd_ready_q, cmd_ready_d;
  logic                         job_start_q, job_start_d;
  logic [C_PARAM_WIDTH-1:0]     params_q, params_d;
  logic                         fack_q, fack_d;
  logic                         fdone_q, fdone_d;
  logic                         cack_q, cack_d;
  logic                         busy_q, busy_d;
  logic [C_FETCH_CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [C_JOB_CNT_WIDTH-1:0]   jobs_q, jobs_d;
  logic                         err_timeout_q, err_timeout_d;
  logic                         err_proto_q, err_proto_d;
  logic                         proto_hit;
  logic                         wd_load, wd_en, wd_expired;

  assign wd_load = (state_d != state_q);
  assign wd_en   = (state_q == START) || (state_q == FETCH);

  cnn_layer_accel_watchdog #(.W(WDOG_CNT_WIDTH)) u_wdog (
    .clk     (clk_if),
    .rst     (rst),
    .load    (wd_load),
    .en      (wd_en),
    .limit   (WDOG_LIMIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    params_d    = params_q;
    fetch_cnt_d = fetch_cnt_q;
    jobs_d      = jobs_q;
    fdone_d     = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        params_d    = cmd_params;
        fetch_cnt_d = '0;
        state_d     = START;
      end
      START: begin
        if (wd_expired)      state_d = IDLE;
        else if (job_accept) state_d = RUN;
      end
      RUN: begin
        if (job_fetch_request) state_d = FACK;
        else if (job_complete) state_d = CACK;
      end
      FACK: begin
        state_d = FETCH;
        if (fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + 1'b1;
      end
      // dma_start_q marks the first FETCH cycle, where a stale dma_done is ignored
      FETCH: begin
        if (wd_expired) state_d = IDLE;
        else if (dma_done && !fack_q) begin
          fdone_d = 1'b1;
          state_d = RUN;
        end
      end
      CACK: if (!job_complete) begin
        jobs_d  = jobs_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    job_start_d = (state_d == START);
    cack_d      = (state_d == CACK);
    fack_d      = (state_q == FACK);

    proto_hit     = (job_accept && (state_q != START)) || (job_complete && (state_q == START));
    err_timeout_d = wd_expired | (err_timeout_q & ~err_clr);
    err_proto_d   = proto_hit  | (err_proto_q & ~err_clr);
  end

  always_ff @(posedge clk_if) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      job_start_q   <= 1'b0;
      params_q      <= '0;
      fack_q        <= 1'b0;
      fdone_q       <= 1'b0;
      cack_q        <= 1'b0;
      busy_q        <= 1'b0;
      fetch_cnt_q   <= '0;
      jobs_q        <= '0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      job_start_q   <= job_start_d;
      params_q      <= params_d;
      fack_q        <= fack_d;
      fdone_q       <= fdone_d;
      cack_q        <= cack_d;
      busy_q        <= busy_d;
      fetch_cnt_q   <= fetch_cnt_d;
      jobs_q        <= jobs_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign job_start          = job_start_q;
  assign job_parameters     = params_q;
  assign job_fetch_ack      = fack_q;
  assign dma_start          = fack_q;
  assign job_fetch_complete = fdone_q;
  assign job_complete_ack   = cack_q;
  assign busy               = busy_q;
  assign fetch_count        = fetch_cnt_q;
  assign jobs_done          = jobs_q;
  assign err_timeout        = err_timeout_q;
  assign err_proto          = err_proto_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_dispatcher.sv
// Directed bench for the job dispatcher with a scoreboard of expected
// descriptors (checked at each job_start rise) and fetch counts (checked at each fetch completion).
module tb_cnn_layer_accel_job_dispatcher;

  localparam int PW = 128;
  localparam int FW = 16;
  localparam int JW = 32;

  logic          clk_if = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [PW-1:0] cmd_params = '0;
  logic          job_start;
  logic          job_accept = 1'b0;
  logic [PW-1:0] job_parameters;
  logic          job_fetch_request = 1'b0;
  logic          job_fetch_ack;
  logic          job_fetch_complete;
  logic          job_complete = 1'b0;
  logic          job_complete_ack;
  logic          dma_start;
  logic          dma_done = 1'b0;
  logic          busy;
  logic [FW-1:0] fetch_count;
  logic [JW-1:0] jobs_done;
  logic          err_timeout;
  logic          err_proto;
  logic          err_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_params[$];
  logic [FW-1:0] exp_fc[$];
  logic          start_prev = 1'b0;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_job_dispatcher #(
    .C_PARAM_WIDTH(PW), .C_TIMEOUT_CYCLES(50), .C_FETCH_CNT_WIDTH(FW), .C_JOB_CNT_WIDTH(JW)
  ) dut (
    .clk_if(clk_if), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_params(cmd_params), .job_start(job_start), .job_accept(job_accept),
    .job_parameters(job_parameters), .job_fetch_request(job_fetch_request),
    .job_fetch_ack(job_fetch_ack), .job_fetch_complete(job_fetch_complete),
    .job_complete(job_complete), .job_complete_ack(job_complete_ack),
    .dma_start(dma_start), .dma_done(dma_done), .busy(busy),
    .fetch_count(fetch_count), .jobs_done(jobs_done), .err_timeout(err_timeout),
    .err_proto(err_proto), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_if);
    #1;
  endtask

  // scoreboard side: pop on DUT output events
  always @(negedge clk_if) begin
    if (job_start && !start_prev) begin
      if (exp_params.size() == 0) chk("unexpected_job_start", 1, 0);
      else chk("sb_job_parameters", job_parameters, exp_params.pop_front());
    end
    if (job_fetch_complete) begin
      if (exp_fc.size() == 0) chk("unexpected_fetch_complete", 1, 0);
      else chk("sb_fetch_count", PW'(fetch_count), PW'(exp_fc.pop_front()));
    end
    start_prev = job_start;
  end

  initial begin
    int n;
    // reset
    tick(2);
    chk("rst_cmd_ready", PW'(cmd_ready), 0);
    chk("rst_busy", PW'(busy), 0);
    chk("rst_params", job_parameters, 0);
    chk("rst_jobs_done", PW'(jobs_done), 0);
    chk("rst_errs", PW'({err_timeout, err_proto}), 0);
    rst = 1'b0;
    tick();
    chk("cmd_ready_after_rst", PW'(cmd_ready), 1);

    // basic job, no fetch
    cmd_params = PW'(128'hA5); cmd_valid = 1'b1; exp_params.push_back(PW'(128'hA5));
    tick(); cmd_valid = 1'b0;
    chk("t1_job_start", PW'(job_start), 1);
    chk("t1_cmd_ready_low", PW'(cmd_ready), 0);
    job_accept = 1'b1; tick(); job_accept = 1'b0;
    chk("t1_start_drop", PW'(job_start), 0);
    n = 0;
    job_complete = 1'b1;
    repeat (4) begin tick(); if (job_complete_ack) n++; end
    job_complete = 1'b0;
    tick(); if (job_complete_ack) n++;
    chk("t1_ack_cycles", PW'(n), 4);
    chk("t1_jobs_done", PW'(jobs_done), 1);
    chk("t1_cmd_ready", PW'(cmd_ready), 1);

    // three fetches
    cmd_params = PW'(128'h1234); cmd_valid = 1'b1; exp_params.push_back(PW'(128'h1234));
    tick(); cmd_valid = 1'b0;
    job_accept = 1'b1; tick(); job_accept = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      job_fetch_request = 1'b1; exp_fc.push_back(FW'(k));
      tick(2);
      chk("t2_fetch_ack", PW'(job_fetch_ack), 1);
      chk("t2_dma_start", PW'(dma_start), 1);
      job_fetch_request = 1'b0;
      if (k == 1) begin
        dma_done = 1'b1; tick(); dma_done = 1'b0;
        chk("t2_early_done_ignored", PW'({job_fetch_complete, busy}), 1);
        chk("t2_ack_pulse", PW'(job_fetch_ack), 0);
        tick(8);
      end else tick(9);
      dma_done = 1'b1; tick(); dma_done = 1'b0;
      chk("t2_fetch_complete", PW'(job_fetch_complete), 1);
      tick();
      chk("t2_fetch_complete_pulse", PW'(job_fetch_complete), 0);
    end
    chk("t2_fetch_count", PW'(fetch_count), 3);
    job_complete = 1'b1; tick(2); job_complete = 1'b0; tick(2);
    chk("t2_jobs_done", PW'(jobs_done), 2);

    // simultaneous fetch request and completion
    cmd_params = PW'(128'hBEEF); cmd_valid = 1'b1; exp_params.push_back(PW'(128'hBEEF));
    tick(); cmd_valid = 1'b0;
    job_accept = 1'b1; tick(); job_accept = 1'b0;
    job_fetch_request = 1'b1; job_complete = 1'b1; exp_fc.push_back(FW'(1));
    tick(2);
    chk("t3_fetch_first", PW'({job_fetch_ack, job_complete_ack}), 2);
    job_fetch_request = 1'b0;
    tick();
    dma_done = 1'b1; tick(); dma_done = 1'b0;
    chk("t3_fetch_complete", PW'(job_fetch_complete), 1);
    tick();
    chk("t3_complete_ack", PW'(job_complete_ack), 1);
    job_complete = 1'b0; tick();
    chk("t3_ack_drop", PW'(job_complete_ack), 0);
    chk("t3_fetch_count", PW'(fetch_count), 1);
    chk("t3_jobs_done", PW'(jobs_done), 3);
    chk("t3_no_proto", PW'(err_proto), 0);

    // watchdog timeout in START
    cmd_params = PW'(128'h77); cmd_valid = 1'b1; exp_params.push_back(PW'(128'h77));
    tick(); cmd_valid = 1'b0;
    n = 0;
    while (job_start && n < 200) begin n++; tick(); end
    chk("t4_start_cycles", PW'(n), 50);
    chk("t4_err_timeout", PW'(err_timeout), 1);
    chk("t4_idle", PW'({job_start, busy}), 0);
    chk("t4_jobs_done", PW'(jobs_done), 3);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4_err_clr", PW'(err_timeout), 0);

    // protocol error, set beats clear
    job_accept = 1'b1; tick(); job_accept = 1'b0;
    chk("t5_err_proto", PW'(err_proto), 1);
    chk("t5_state_kept", PW'({busy, cmd_ready}), 1);
    job_accept = 1'b1; err_clr = 1'b1; tick(); job_accept = 1'b0;
    chk("t5_set_wins", PW'(err_proto), 1);
    tick(); err_clr = 1'b0;
    chk("t5_clr", PW'(err_proto), 0);

    // reset during FETCH
    cmd_params = PW'(128'h99); cmd_valid = 1'b1; exp_params.push_back(PW'(128'h99));
    tick(); cmd_valid = 1'b0;
    job_accept = 1'b1; tick(); job_accept = 1'b0;
    job_fetch_request = 1'b1; tick(2); job_fetch_request = 1'b0; tick();
    chk("t5_in_fetch", PW'({busy, fetch_count}), PW'({1'b1, 16'd1}));
    rst = 1'b1; tick();
    chk("t5_rst_outs", PW'({cmd_ready, busy, job_start, job_fetch_ack, dma_start, job_complete_ack}), 0);
    chk("t5_rst_counts", PW'({fetch_count, jobs_done}), 0);
    chk("t5_rst_params", job_parameters, 0);
    rst = 1'b0; tick();
    chk("t5_cmd_ready", PW'(cmd_ready), 1);

    // back-to-back descriptors with cmd_valid held
    cmd_params = PW'(128'hC1); cmd_valid = 1'b1; exp_params.push_back(PW'(128'hC1));
    tick();
    cmd_params = PW'(128'hC2); exp_params.push_back(PW'(128'hC2));
    chk("t6_first", job_parameters, PW'(128'hC1));
    job_accept = 1'b1; tick(); job_accept = 1'b0;
    tick(3);
    chk("t6_held_off", PW'(cmd_ready), 0);
    chk("t6_params_stable", job_parameters, PW'(128'hC1));
    job_complete = 1'b1; tick(); job_complete = 1'b0; tick();
    chk("t6_idle_ready", PW'(cmd_ready), 1);
    chk("t6_params_before", job_parameters, PW'(128'hC1));
    tick(); cmd_valid = 1'b0;
    chk("t6_second", job_parameters, PW'(128'hC2));
    chk("t6_second_start", PW'(job_start), 1);
    job_accept = 1'b1; tick(); job_accept = 1'b0;
    job_complete = 1'b1; tick(); job_complete = 1'b0; tick(2);
    chk("t6_jobs_done", PW'(jobs_done), 2);

    chk("sb_params_drained", PW'(exp_params.size()), 0);
    chk("sb_fc_drained", PW'(exp_fc.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
